apple_spawner: RTL and testbench

- Parametrised successor to the fixed 39x29 apple generator: grid bounds, tick rate, LFSR seed and retry budget are all parameters.
- Detects "head on apple" on a tick, pulses add_cube, then picks a new apple cell.
- Candidate cells come from a 16-bit LFSR with rejection sampling. Each candidate is checked against the head and against the snake body via a query port.
- Falls back to a deterministic scan when the retry budget is exhausted. Sits between the snake body/control logic and the VGA renderer.

---
 rtl/apple_spawner.sv | 207 ++++++++++++++++++++
 tb/tb_apple_spawner.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apple_spawner.sv
// Apple placement: eat detection on tick, LFSR rejection sampling, scan fallback.
// Optional APPLE_TIMEOUT_EN relocates an uneaten apple after TIMEOUT_TICKS ticks.
module apple_spawner #(
   parameter int          X_W       = 6,
   parameter int          Y_W       = 5,
   parameter int          X_MIN     = 1,
   parameter int          X_MAX     = 38,
   parameter int          Y_MIN     = 1,
   parameter int          Y_MAX     = 28,
   parameter int          RESET_X   = 24,
   parameter int          RESET_Y   = 10,
   parameter int          TICK_DIV  = 250000,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          MAX_TRIES = 15
`ifdef APPLE_TIMEOUT_EN
   ,
   parameter int          TIMEOUT_TICKS = 40
`endif
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [X_W-1:0] head_x,
   input  logic [Y_W-1:0] head_y,
   output logic [X_W-1:0] cand_x,
   output logic [Y_W-1:0] cand_y,
   input  logic           cand_occupied,
   output logic [X_W-1:0] apple_x,
   output logic [Y_W-1:0] apple_y,
   output logic           apple_valid,
   output logic           add_cube,
   output logic           board_full
);

   localparam logic [X_W-1:0] XLO = X_W'(X_MIN);
   localparam logic [X_W-1:0] XHI = X_W'(X_MAX);
   localparam logic [Y_W-1:0] YLO = Y_W'(Y_MIN);
   localparam logic [Y_W-1:0] YHI = Y_W'(Y_MAX);
   localparam logic [X_W-1:0] XRS = X_W'(RESET_X);
   localparam logic [Y_W-1:0] YRS = Y_W'(RESET_Y);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);
   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam logic [TW-1:0] TMAX = TW'(MAX_TRIES);
   localparam logic [15:0] SEED_NZ = (SEED == 16'd0) ? 16'd1 : SEED;

   typedef enum logic [2:0] {IDLE, DRAW, CHECK, SCAN, FULL} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [15:0]    lfsr_q, lfsr_d;
   logic [TW-1:0]  tries_q, tries_d;
   logic [X_W-1:0] cand_x_q, cand_x_d, apple_x_q, apple_x_d;
   logic [Y_W-1:0] cand_y_q, cand_y_d, apple_y_q, apple_y_d;
   logic           valid_q, valid_d;
   logic           add_q, add_d;
   logic           full_q, full_d;

   logic           tick, eat, raw_ok, reject;
   logic [X_W-1:0] raw_x;
   logic [Y_W-1:0] raw_y;
   logic [TW-1:0]  tries_inc;

`ifdef APPLE_TIMEOUT_EN
   localparam int OW = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [OW-1:0] OMAX = OW'(TIMEOUT_TICKS);
   logic [OW-1:0]  to_q, to_d, to_inc;
   assign to_inc = to_q + 1'b1;
`endif

   assign tick      = (cnt_q == CMAX);
   assign raw_x     = lfsr_q[X_W-1:0];
   assign raw_y     = lfsr_q[X_W+Y_W-1:X_W];
   assign raw_ok    = (raw_x >= XLO) && (raw_x <= XHI) &&
                      (raw_y >= YLO) && (raw_y <= YHI);
   assign eat       = valid_q && (head_x == apple_x_q) && (head_y == apple_y_q);
   assign reject    = cand_occupied || ((cand_x_q == head_x) && (cand_y_q == head_y));
   assign tries_inc = tries_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
      tries_d   = tries_q;
      cand_x_d  = cand_x_q;
      cand_y_d  = cand_y_q;
      apple_x_d = apple_x_q;
      apple_y_d = apple_y_q;
      valid_d   = valid_q;
      add_d     = 1'b0;
      full_d    = full_q;
`ifdef APPLE_TIMEOUT_EN
      to_d      = to_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (tick && eat) begin
               add_d   = 1'b1;
               valid_d = 1'b0;
               tries_d = '0;
               state_d = DRAW;
`ifdef APPLE_TIMEOUT_EN
               to_d    = '0;
            end else if (tick) begin
               if (to_inc == OMAX) begin
                  to_d    = '0;
                  valid_d = 1'b0;
                  tries_d = '0;
                  state_d = DRAW;
               end else begin
                  to_d = to_inc;
               end
`endif
            end
         end
         DRAW, CHECK: begin
            if (state_q == DRAW) begin
               cand_x_d = raw_x;
               cand_y_d = raw_y;
            end
            if ((state_q == DRAW) && raw_ok) begin
               state_d = CHECK;
            end else if ((state_q == CHECK) && !reject) begin
               apple_x_d = cand_x_q;
               apple_y_d = cand_y_q;
               valid_d   = 1'b1;
               state_d   = IDLE;
`ifdef APPLE_TIMEOUT_EN
               to_d      = '0;
`endif
            end else begin
               tries_d = tries_inc;
               state_d = DRAW;
               // Budget spent: deterministic scan from the low corner
               if (tries_inc == TMAX) begin
                  state_d  = SCAN;
                  cand_x_d = XLO;
                  cand_y_d = YLO;
               end
            end
         end
         SCAN: begin
            if (!reject) begin
               apple_x_d = cand_x_q;
               apple_y_d = cand_y_q;
               valid_d   = 1'b1;
               state_d   = IDLE;
`ifdef APPLE_TIMEOUT_EN
               to_d      = '0;
`endif
            end else if (cand_x_q != XHI) begin
               cand_x_d = cand_x_q + 1'b1;
            end else if (cand_y_q != YHI) begin
               cand_x_d = XLO;
               cand_y_d = cand_y_q + 1'b1;
            end else begin
               full_d  = 1'b1;
               state_d = FULL;
            end
         end
         FULL: valid_d = 1'b0;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         lfsr_q    <= SEED_NZ;
         tries_q   <= '0;
         cand_x_q  <= XLO;
         cand_y_q  <= YLO;
         apple_x_q <= XRS;
         apple_y_q <= YRS;
         valid_q   <= 1'b1;
         add_q     <= 1'b0;
         full_q    <= 1'b0;
`ifdef APPLE_TIMEOUT_EN
         to_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lfsr_q    <= lfsr_d;
         tries_q   <= tries_d;
         cand_x_q  <= cand_x_d;
         cand_y_q  <= cand_y_d;
         apple_x_q <= apple_x_d;
         apple_y_q <= apple_y_d;
         valid_q   <= valid_d;
         add_q     <= add_d;
         full_q    <= full_d;
`ifdef APPLE_TIMEOUT_EN
         to_q      <= to_d;
`endif
      end
   end

   assign cand_x      = cand_x_q;
   assign cand_y      = cand_y_q;
   assign apple_x     = apple_x_q;
   assign apple_y     = apple_y_q;
   assign apple_valid = valid_q;
   assign add_cube    = add_q;
   assign board_full  = full_q;

endmodule

// File: tb/tb_apple_spawner.sv
// Bench for apple_spawner: transaction-level placement model plus directed checks.
module tb_apple_spawner;

   localparam int TICK = 4;
   localparam int MAXT = 15;
`ifdef APPLE_TIMEOUT_EN
   localparam int TO_TICKS = 3;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] head_x = '0;
   logic [4:0] head_y = '0;
   logic [5:0] cand_x, apple_x;
   logic [4:0] cand_y, apple_y;
   logic       cand_occupied, apple_valid, add_cube, board_full;
   int         mode = 0;

   int n_vec = 0;
   int n_err = 0;

   apple_spawner #(
      .TICK_DIV(TICK)
`ifdef APPLE_TIMEOUT_EN
      , .TIMEOUT_TICKS(TO_TICKS)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .head_x(head_x), .head_y(head_y),
      .cand_x(cand_x), .cand_y(cand_y),
      .cand_occupied(cand_occupied),
      .apple_x(apple_x), .apple_y(apple_y),
      .apple_valid(apple_valid),
      .add_cube(add_cube),
      .board_full(board_full)
   );

   initial forever #5 clk = ~clk;

   // mode 0 empty, 1 all but (5,3), 2 all, 3 every x below 20
   function automatic logic occ(input int md, input int x, input int y);
      case (md)
         1: return !(x == 5 && y == 3);
         2: return 1'b1;
         3: return x < 20;
         default: return 1'b0;
      endcase
   endfunction

   assign cand_occupied = occ(mode, int'(cand_x), int'(cand_y));

   function automatic logic [15:0] lfsr_at(input int n);
      logic [15:0] v;
      v = 16'hACE1;
      for (int i = 0; i < n; i++)
         v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
      return v;
   endfunction

   // model: phase 0 idle with apple, 1 searching, 2 board full
   int ecnt = 0, m_phase = 0, m_ax = 24, m_ay = 10;
   int m_eat_edge = -1, m_done = 0, m_to = 0;
   int n_ax = 0, n_ay = 0;
   bit n_full = 0;

   // Outcome of a search begun at edge e: edge at which it resolves.
   function automatic void predict(input int e);
      int n, tries, s, x, y;
      logic [15:0] v;
      bit scan;
      n = e + 1;
      tries = 0;
      scan = 0;
      s = 0;
      n_full = 0;
      while (!scan) begin
         v = lfsr_at(n - 1);
         x = int'(v[5:0]);
         y = int'(v[10:6]);
         if (x < 1 || x > 38 || y < 1 || y > 28) begin
            tries++;
            if (tries == MAXT) begin scan = 1; s = n + 1; end
            else n = n + 1;
         end else if (occ(mode, x, y) || (x == int'(head_x) && y == int'(head_y))) begin
            tries++;
            if (tries == MAXT) begin scan = 1; s = n + 2; end
            else n = n + 2;
         end else begin
            m_done = n + 1; n_ax = x; n_ay = y;
            return;
         end
      end
      for (int yy = 1; yy <= 28; yy++)
         for (int xx = 1; xx <= 38; xx++) begin
            if (!occ(mode, xx, yy) && !(xx == int'(head_x) && yy == int'(head_y))) begin
               m_done = s; n_ax = xx; n_ay = yy;
               return;
            end
            s++;
         end
      n_full = 1;
      m_done = s - 1;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         ecnt = 0; m_phase = 0; m_ax = 24; m_ay = 10;
         m_eat_edge = -1; m_to = 0;
      end else begin
         ecnt++;
         if (m_phase == 1) begin
            if (ecnt == m_done) begin
               if (n_full) m_phase = 2;
               else begin m_phase = 0; m_ax = n_ax; m_ay = n_ay; m_to = 0; end
            end
         end else if (m_phase == 0 && ecnt % TICK == 0) begin
            if (int'(head_x) == m_ax && int'(head_y) == m_ay) begin
               m_eat_edge = ecnt; m_to = 0;
               predict(ecnt);
               m_phase = 1;
            end
`ifdef APPLE_TIMEOUT_EN
            else begin
               m_to++;
               if (m_to == TO_TICKS) begin
                  m_to = 0;
                  predict(ecnt);
                  m_phase = 1;
               end
            end
`endif
         end
      end
   end

   initial forever begin
      logic [13:0] e, a;
      bit ev;
      @(negedge clk);
      ev = (m_phase == 0);
      e = {ecnt == m_eat_edge, ev, m_phase == 2,
           ev ? 6'(m_ax) : 6'd0, ev ? 5'(m_ay) : 5'd0};
      a = {add_cube, apple_valid, board_full,
           ev ? apple_x : 6'd0, ev ? apple_y : 5'd0};
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL cycle@%0d: got add/valid/full/x/y=%b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
                  ecnt, a[13], a[12], a[11], a[10:5], a[4:0],
                  e[13], e[12], e[11], e[10:5], e[4:0]);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_ax"}, int'(apple_x), 24);
      chk({nm, "_ay"}, int'(apple_y), 10);
      chk({nm, "_valid"}, int'(apple_valid), 1);
      chk({nm, "_add"}, int'(add_cube), 0);
      chk({nm, "_full"}, int'(board_full), 0);
      chk({nm, "_cx"}, int'(cand_x), 1);
      chk({nm, "_cy"}, int'(cand_y), 1);
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 chk_reset(nm);
      @(negedge clk);
      #2 rst = 1'b1;
   endtask

   task automatic wait_sig(input int sel, input logic lvl, input int budget, input string nm);
      bit hit;
      hit = 0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(posedge clk);
         #1;
         if ((sel == 0 ? apple_valid : board_full) == lvl) hit = 1;
      end
      chk({nm, "_timeout"}, int'(hit), 1);
   endtask

`ifdef APPLE_TIMEOUT_EN
   task automatic wait_tick();
      bit hit;
      hit = 0;
      for (int i = 0; i < TICK && !hit; i++) begin
         @(posedge clk);
         #1;
         if (ecnt % TICK == 0) hit = 1;
      end
      chk("tick_wait", int'(hit), 1);
   endtask
`endif

   initial begin
      do_reset("rst0");
      repeat (3 * TICK) @(posedge clk);
      #1;
`ifndef APPLE_TIMEOUT_EN
      chk("idle_ax", int'(apple_x), 24);
      chk("idle_ay", int'(apple_y), 10);
      chk("idle_valid", int'(apple_valid), 1);
`endif

      head_x = 6'd24; head_y = 5'd10;
      do_reset("rst1");
      repeat (4) @(posedge clk);
      #1;
      chk("eat_add", int'(add_cube), 1);
      chk("eat_valid", int'(apple_valid), 0);
      @(posedge clk);
      #1;
      chk("draw_add", int'(add_cube), 0);
      chk("draw_valid", int'(apple_valid), 0);
      chk("draw_cx", int'(cand_x), 14);
      chk("draw_cy", int'(cand_y), 17);
      @(posedge clk);
      #1;
      chk("place_valid", int'(apple_valid), 1);
      chk("place_ax", int'(apple_x), 14);
      chk("place_ay", int'(apple_y), 17);

      #1 head_x = 6'd14; head_y = 5'd17; mode = 1;
      wait_sig(0, 1'b0, 10, "scan_eat");
      wait_sig(0, 1'b1, 300, "scan_place");
      chk("scan_ax", int'(apple_x), 5);
      chk("scan_ay", int'(apple_y), 3);

      #1 head_x = 6'd5; head_y = 5'd3; mode = 2;
      wait_sig(0, 1'b0, 10, "full_eat");
      wait_sig(1, 1'b1, 1600, "full_set");
      chk("full_valid", int'(apple_valid), 0);
      repeat (3 * TICK) @(posedge clk);
      #1;
      chk("full_hold", int'(board_full), 1);
      chk("full_hold_valid", int'(apple_valid), 0);
      chk("full_hold_add", int'(add_cube), 0);

      head_x = 6'd24; head_y = 5'd10; mode = 0;
      do_reset("rst2");
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1 chk_reset("rst_mid");
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("reseed_valid", int'(apple_valid), 1);
      chk("reseed_ax", int'(apple_x), 14);
      chk("reseed_ay", int'(apple_y), 17);

      #1 head_x = 6'd14; head_y = 5'd17; mode = 3;
      wait_sig(0, 1'b0, 10, "half_eat");
      wait_sig(0, 1'b1, 300, "half_place");
      chk("half_x_free", int'(apple_x >= 6'd20), 1);

`ifdef APPLE_TIMEOUT_EN
      #1 head_x = 6'd0; head_y = 5'd0; mode = 0;
      wait_sig(0, 1'b0, 4 * TO_TICKS + 4, "to_move");
      chk("to_add", int'(add_cube), 0);
      wait_sig(0, 1'b1, 300, "to_place");
      wait_tick();
      wait_tick();
      head_x = apple_x; head_y = apple_y;
      wait_tick();
      chk("to_eat_add", int'(add_cube), 1);
      wait_sig(0, 1'b1, 300, "to_eat_place");
`endif

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
